// File: rtl/dmem_arbiter_pkg.sv
// dmem_arbiter_pkg: shared types and constants for the data memory arbiter
package dmem_arbiter_pkg;
  localparam int MEM_ADDR_W = 9;
  localparam int MEM_DATA_W = 32;
  localparam logic [2:0] DBG_FUNCT3 = 3'b010;
  typedef enum logic {CPU_OWN = 1'b0, DBG_BURST = 1'b1} arb_state_e;
  typedef struct packed {
    logic rd;
    logic wr;
    logic [MEM_ADDR_W-1:0] addr;
    logic [MEM_DATA_W-1:0] wdata;
    logic [2:0] funct3;
  } mem_req_t;
endpackage

// File: rtl/dmem_arbiter_sat_counter.sv
// arb_sat_counter: saturating up-counter with synchronous clear
module arb_sat_counter #(
  parameter int MAX = 1,
  parameter int W = $clog2(MAX + 1)
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic inc,
  output logic [W-1:0] cnt
);
  // count up on inc, stick at MAX, clear wins over increment
  always_ff @(posedge clk)
    if (reset || clr) cnt <= '0;
    else if (inc && cnt != W'(MAX)) cnt <= cnt + 1'b1;
endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the data memory port between the CPU MEM stage and a debug/loader port
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int ADDR_W = MEM_ADDR_W,
  parameter int DATA_W = MEM_DATA_W,
  parameter int MAX_WAIT = 8,
  parameter int BURST_MAX = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic cpu_rd,
  input  logic cpu_wr,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  input  logic [2:0] cpu_funct3,
  output logic cpu_stall,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic dbg_req,
  input  logic dbg_we,
  input  logic dbg_last,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [DATA_W-1:0] dbg_wdata,
  output logic dbg_gnt,
  output logic dbg_rvalid,
  output logic [DATA_W-1:0] dbg_rdata,
  output logic mem_rd,
  output logic mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [2:0] mem_funct3,
  input  logic [DATA_W-1:0] mem_rdata
);
  localparam int WW = $clog2(MAX_WAIT + 1);
  localparam int BW = $clog2(BURST_MAX + 1);
  arb_state_e state, state_nx;
  mem_req_t cpu_r, dbg_r, mem_r;
  logic cpu_req, force_gnt, gnt, beat_done, idle_q, rd_pend, rd_owner;
  logic [WW-1:0] wait_cnt;
  logic [BW-1:0] beat_cnt;
  logic [DATA_W-1:0] dbg_rdata_q;
  // grant decision and memory port mux; reset forces every drive to idle
  always_comb begin
    cpu_req = cpu_rd | cpu_wr;
    cpu_r = '{rd: cpu_rd & ~cpu_wr, wr: cpu_wr, addr: MEM_ADDR_W'(cpu_addr),
              wdata: MEM_DATA_W'(cpu_wdata), funct3: cpu_funct3};
    dbg_r = '{rd: ~dbg_we, wr: dbg_we, addr: MEM_ADDR_W'(dbg_addr),
              wdata: MEM_DATA_W'(dbg_wdata), funct3: DBG_FUNCT3};
    force_gnt = wait_cnt == WW'(MAX_WAIT);
    gnt = !reset && dbg_req && (state == DBG_BURST || !cpu_req || force_gnt);
    beat_done = dbg_last || beat_cnt == BW'(BURST_MAX - 1);
    state_nx = gnt ? (beat_done ? CPU_OWN : DBG_BURST)
             : (state == DBG_BURST && !dbg_req && idle_q) ? CPU_OWN : state;
    mem_r = gnt ? dbg_r : (!reset && state == CPU_OWN) ? cpu_r : '0;
    cpu_stall = !reset && cpu_req && (gnt || state == DBG_BURST);
    dbg_gnt = gnt;
    mem_rd = mem_r.rd;
    mem_wr = mem_r.wr;
    mem_addr = ADDR_W'(mem_r.addr);
    mem_wdata = DATA_W'(mem_r.wdata);
    mem_funct3 = mem_r.funct3;
    cpu_rdata = mem_rdata;
    dbg_rvalid = !reset && rd_pend && rd_owner;
    dbg_rdata = dbg_rvalid ? mem_rdata : dbg_rdata_q;
  end
  // ownership state, idle-drop tracking and read-return bookkeeping
  always_ff @(posedge clk) begin
    state <= reset ? CPU_OWN : state_nx;
    idle_q <= !reset && state == DBG_BURST && !dbg_req;
    rd_pend <= !reset && mem_rd;
    rd_owner <= gnt;
    dbg_rdata_q <= reset ? '0 : dbg_rdata;
  end
  arb_sat_counter #(.MAX(MAX_WAIT), .W(WW)) u_wait (
    .clk(clk), .reset(reset), .clr(gnt || !dbg_req), .inc(dbg_req && !gnt), .cnt(wait_cnt)
  );
  arb_sat_counter #(.MAX(BURST_MAX), .W(BW)) u_beat (
    .clk(clk), .reset(reset), .clr(state_nx == CPU_OWN), .inc(gnt), .cnt(beat_cnt)
  );
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: scoreboard bench for the data memory arbiter
module tb_dmem_arbiter;
  import dmem_arbiter_pkg::*;
  logic clk = 0, reset = 1;
  logic cpu_rd, cpu_wr, cpu_stall, dbg_req, dbg_we, dbg_last, dbg_gnt, dbg_rvalid;
  logic mem_rd, mem_wr;
  logic [8:0] cpu_addr, dbg_addr, mem_addr;
  logic [31:0] cpu_wdata, cpu_rdata, dbg_wdata, dbg_rdata, mem_wdata, mem_rdata = 0, mon_exp;
  logic [2:0] cpu_funct3, mem_funct3;
  logic [31:0] mem [0:511];
  logic [31:0] ref_mem [0:511];
  logic [31:0] dq [$];
  int total = 0, bad = 0;

  dmem_arbiter dut (
    .clk(clk), .reset(reset), .cpu_rd(cpu_rd), .cpu_wr(cpu_wr), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_funct3(cpu_funct3), .cpu_stall(cpu_stall), .cpu_rdata(cpu_rdata),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_last(dbg_last), .dbg_addr(dbg_addr),
    .dbg_wdata(dbg_wdata), .dbg_gnt(dbg_gnt), .dbg_rvalid(dbg_rvalid), .dbg_rdata(dbg_rdata),
    .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_funct3(mem_funct3), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_wr) mem[mem_addr] <= mem_wdata;
    if (mem_rd) mem_rdata <= mem[mem_addr];
  end

  always @(negedge clk)
    if (dbg_rvalid) begin
      total++;
      if (dq.size() == 0) begin
        bad++;
        $display("FAIL rvalid_unexpected got=%h want=none", dbg_rdata);
      end else begin
        mon_exp = dq.pop_front();
        if (dbg_rdata !== mon_exp) begin
          bad++;
          $display("FAIL dbg_rdata got=%h want=%h", dbg_rdata, mon_exp);
        end
      end
    end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic idle_all();
    cpu_rd = 0; cpu_wr = 0; cpu_addr = 0; cpu_wdata = 0; cpu_funct3 = 0;
    dbg_req = 0; dbg_we = 0; dbg_last = 0; dbg_addr = 0; dbg_wdata = 0;
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    idle_all();
    reset = 1;
    step();
    step();
    @(negedge clk);
    total++;
    if ({cpu_stall, dbg_gnt, dbg_rvalid, dbg_rdata} !== 35'd0) begin
      bad++;
      $display("FAIL reset_ctl got=%h want=0", {cpu_stall, dbg_gnt, dbg_rvalid, dbg_rdata});
    end
    total++;
    if ({mem_rd, mem_wr, mem_addr, mem_wdata, mem_funct3} !== 46'd0) begin
      bad++;
      $display("FAIL reset_mem got=%h want=0", {mem_rd, mem_wr, mem_addr, mem_wdata, mem_funct3});
    end
    total++;
    if (dut.state !== CPU_OWN) begin
      bad++;
      $display("FAIL reset_state got=%0d want=%0d", dut.state, CPU_OWN);
    end
    step();
    reset = 0;
  endtask

  task automatic test_cpu_only();
    step();
    cpu_wr = 1; cpu_addr = 9'h010; cpu_wdata = 32'hDEADBEEF; cpu_funct3 = 3'b010;
    ref_mem[9'h010] = 32'hDEADBEEF;
    @(negedge clk);
    total++;
    if ({cpu_stall, mem_rd, mem_wr, mem_addr, mem_wdata} !== {3'b001, 9'h010, 32'hDEADBEEF}) begin
      bad++;
      $display("FAIL cpu_write got=%h want=%h", {cpu_stall, mem_rd, mem_wr, mem_addr, mem_wdata},
               {3'b001, 9'h010, 32'hDEADBEEF});
    end
    step();
    cpu_wr = 0; cpu_rd = 1;
    @(negedge clk);
    total++;
    if ({cpu_stall, mem_rd, mem_wr} !== 3'b010) begin
      bad++;
      $display("FAIL cpu_read got=%b want=010", {cpu_stall, mem_rd, mem_wr});
    end
    step();
    cpu_rd = 0;
    @(negedge clk);
    total++;
    if (cpu_rdata !== ref_mem[9'h010]) begin
      bad++;
      $display("FAIL cpu_rdata got=%h want=%h", cpu_rdata, ref_mem[9'h010]);
    end
    total++;
    if ({mem_rd, mem_wr} !== 2'b00) begin
      bad++;
      $display("FAIL idle_mem got=%b want=00", {mem_rd, mem_wr});
    end
  endtask

  task automatic test_dbg_idle();
    step();
    dbg_req = 1; dbg_we = 1; dbg_last = 1; dbg_addr = 9'h020; dbg_wdata = 32'h12345678;
    ref_mem[9'h020] = 32'h12345678;
    @(negedge clk);
    total++;
    if ({dbg_gnt, mem_rd, mem_wr, mem_funct3, mem_addr, mem_wdata} !==
        {3'b101, 3'b010, 9'h020, 32'h12345678}) begin
      bad++;
      $display("FAIL dbg_write got=%h want=%h", {dbg_gnt, mem_rd, mem_wr, mem_funct3, mem_addr, mem_wdata},
               {3'b101, 3'b010, 9'h020, 32'h12345678});
    end
    step();
    dbg_we = 0;
    dq.push_back(ref_mem[9'h020]);
    @(negedge clk);
    total++;
    if ({dut.state, dbg_gnt, mem_rd} !== {CPU_OWN, 2'b11}) begin
      bad++;
      $display("FAIL dbg_single_state got=%b want=%b", {dut.state, dbg_gnt, mem_rd}, {CPU_OWN, 2'b11});
    end
    step();
    idle_all();
    step();
  endtask

  task automatic test_starvation();
    logic eg;
    step();
    cpu_rd = 1; cpu_addr = 9'h030; cpu_funct3 = 3'b010;
    dbg_req = 1; dbg_we = 1; dbg_last = 1; dbg_addr = 9'h040; dbg_wdata = 32'hCAFEF00D;
    ref_mem[9'h040] = 32'hCAFEF00D;
    for (int c = 0; c < 10; c++) begin
      if (c > 0) begin
        step();
        if (c == 9) dbg_req = 0;
      end
      @(negedge clk);
      eg = (c == 8);
      total++;
      if ({dbg_gnt, cpu_stall} !== {eg, eg}) begin
        bad++;
        $display("FAIL starve_c%0d got=%b want=%b", c, {dbg_gnt, cpu_stall}, {eg, eg});
      end
    end
    step();
    idle_all();
    dbg_req = 1; dbg_addr = 9'h040; dbg_last = 1;
    dq.push_back(ref_mem[9'h040]);
    step();
    idle_all();
    step();
  endtask

  task automatic test_burst();
    logic g, eg;
    int beat = 0;
    step();
    cpu_rd = 1; cpu_addr = 9'h060; cpu_funct3 = 3'b010;
    dbg_req = 1; dbg_we = 0; dbg_last = 0; dbg_addr = 9'h050;
    dq.push_back(ref_mem[9'h050]);
    g = 0;
    for (int c = 0; c < 24; c++) begin
      if (c > 0) begin
        step();
        if (g) begin
          beat++;
          if (beat == 6) dbg_req = 0;
          else begin
            dbg_addr = 9'(32'h50 + beat);
            dbg_last = (beat == 5);
            dq.push_back(ref_mem[dbg_addr]);
          end
        end
      end
      @(negedge clk);
      eg = (c inside {8, 9, 10, 11, 20, 21});
      g = dbg_gnt;
      total++;
      if ({dbg_gnt, cpu_stall} !== {eg, eg}) begin
        bad++;
        $display("FAIL burst_c%0d got=%b want=%b", c, {dbg_gnt, cpu_stall}, {eg, eg});
      end
      if (c == 12) begin
        total++;
        if ({mem_rd, mem_addr} !== {1'b1, 9'h060}) begin
          bad++;
          $display("FAIL burst_cpu_slot got=%h want=%h", {mem_rd, mem_addr}, {1'b1, 9'h060});
        end
      end
    end
    step();
    idle_all();
    step();
    step();
    @(negedge clk);
    total++;
    if (dq.size() != 0) begin
      bad++;
      $display("FAIL burst_pending got=%0d want=0", dq.size());
    end
  endtask

  task automatic test_idle_drop();
    step();
    dbg_req = 1; dbg_we = 0; dbg_last = 0; dbg_addr = 9'h080;
    dq.push_back(ref_mem[9'h080]);
    for (int c = 0; c < 4; c++) begin
      if (c > 0) begin
        step();
        dbg_req = 0; cpu_rd = 1; cpu_addr = 9'h010; cpu_funct3 = 3'b010;
      end
      @(negedge clk);
      total++;
      if ({dbg_gnt, cpu_stall} !== {c == 0, c == 1 || c == 2}) begin
        bad++;
        $display("FAIL idle_drop_c%0d got=%b want=%b", c, {dbg_gnt, cpu_stall}, {c == 0, c == 1 || c == 2});
      end
    end
    step();
    idle_all();
    step();
  endtask

  task automatic test_reset_mid_burst();
    step();
    dbg_req = 1; dbg_we = 0; dbg_last = 0; dbg_addr = 9'h070;
    step();
    dbg_addr = 9'h071;
    reset = 1;
    @(negedge clk);
    total++;
    if ({dbg_gnt, dbg_rvalid, cpu_stall, mem_rd, mem_wr} !== 5'b0) begin
      bad++;
      $display("FAIL rst_burst_outs got=%b want=00000", {dbg_gnt, dbg_rvalid, cpu_stall, mem_rd, mem_wr});
    end
    step();
    reset = 0;
    idle_all();
    cpu_rd = 1; cpu_addr = 9'h010; cpu_funct3 = 3'b010;
    @(negedge clk);
    total++;
    if ({cpu_stall, mem_rd, mem_addr, dbg_rvalid, dbg_rdata} !== {2'b01, 9'h010, 1'b0, 32'h0}) begin
      bad++;
      $display("FAIL rst_burst_cpu got=%h want=%h", {cpu_stall, mem_rd, mem_addr, dbg_rvalid, dbg_rdata},
               {2'b01, 9'h010, 1'b0, 32'h0});
    end
    total++;
    if (dut.state !== CPU_OWN) begin
      bad++;
      $display("FAIL rst_burst_state got=%0d want=%0d", dut.state, CPU_OWN);
    end
    step();
    cpu_rd = 0;
    @(negedge clk);
    total++;
    if (cpu_rdata !== ref_mem[9'h010]) begin
      bad++;
      $display("FAIL rst_burst_rdata got=%h want=%h", cpu_rdata, ref_mem[9'h010]);
    end
  endtask

  initial begin
    for (int i = 0; i < 512; i++) begin
      mem[i] = 32'hA5000000 | i;
      ref_mem[i] = 32'hA5000000 | i;
    end
    test_reset();
    test_cpu_only();
    test_dbg_idle();
    test_starvation();
    test_burst();
    test_idle_drop();
    test_reset_mid_burst();
    step();
    step();
    total++;
    if (dq.size() != 0) begin
      bad++;
      $display("FAIL final_pending got=%0d want=0", dq.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
